// File: rtl/input_buffer.sv
// Per-port input flit FIFO for the mesh NoC router: in-order storage with
// registered read data and full/empty status derived from an occupancy count.
module input_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAM_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             wr_acc;
    logic             rd_acc;

    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);

    // A write while full is still legal when a read frees the slot in the same edge.
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_acc) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is left uninitialised on reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else if (rd_acc) begin
            data_out <= mem[rd_ptr_reg];
        end
    end

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: a vector table of per-cycle stimulus and
// expected outputs, plus hand-written reset sequences.
module tb_input_buffer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    input_buffer #(.DATA_WIDTH(8), .RAM_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic rd, input logic [7:0] din,
                                input logic [7:0] dout, input logic f, input logic e);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.full = f; v.empty = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic wr, input logic rd, input logic [7:0] din);
        wr_en = wr; rd_en = rd; data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        rst = 1'b1;

        // Fill 4..12: the ninth write (12) is dropped.
        for (int k = 1; k <= 9; k++)
            add(1, 0, 8'(k + 3), 8'h00, k >= 8, 0);
        // Drain: 4..11, ninth read ignored.
        for (int k = 1; k <= 9; k++)
            add(0, 1, 8'h00, (k <= 8) ? 8'(k + 3) : 8'd11, 0, k >= 8);
        // Move pointers to 5, then a 6-word burst that wraps.
        for (int k = 0; k < 5; k++)
            add(1, 0, 8'(8'h10 + k), 8'd11, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 1, 8'h00, 8'(8'h10 + k), 0, k == 4);
        for (int k = 0; k < 6; k++)
            add(1, 0, 8'(8'hA0 + k), 8'h14, 0, 0);
        for (int k = 0; k < 6; k++)
            add(0, 1, 8'h00, 8'(8'hA0 + k), 0, k == 5);
        add(0, 0, 8'hEE, 8'hA5, 0, 1);
        // Simultaneous access while full.
        for (int k = 0; k < 8; k++)
            add(1, 0, 8'(8'hB0 + k), 8'hA5, k == 7, 0);
        add(1, 1, 8'h55, 8'hB0, 1, 0);
        for (int k = 1; k <= 7; k++)
            add(0, 1, 8'h00, 8'(8'hB0 + k), 0, 0);
        add(0, 1, 8'h00, 8'h55, 0, 1);
        // Simultaneous access while empty: only the write lands.
        add(1, 1, 8'h33, 8'h55, 0, 0);
        add(0, 1, 8'h00, 8'h33, 0, 1);

        // Asynchronous reset with no clock edge.
        #1 rst = 1'b0;
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_empty", {7'b0, empty}, 8'h01);
        check("reset_full", {7'b0, full}, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
            $display("vec %0d wr=%b rd=%b din=%h -> data_out=%h full=%b empty=%b",
                     i, vecs[i].wr, vecs[i].rd, vecs[i].din, data_out, full, empty);
            check($sformatf("vec%0d_data_out", i), data_out, vecs[i].dout);
            check($sformatf("vec%0d_full", i), {7'b0, full}, {7'b0, vecs[i].full});
            check($sformatf("vec%0d_empty", i), {7'b0, empty}, {7'b0, vecs[i].empty});
        end

        // Reset mid-operation with three words stored.
        cycle(1, 0, 8'h01);
        cycle(1, 0, 8'h02);
        cycle(1, 0, 8'h03);
        check("pre_reset_empty", {7'b0, empty}, 8'h00);
        wr_en = 1'b0;
        rst = 1'b0;
        #1;
        check("midreset_data_out", data_out, 8'h00);
        check("midreset_empty", {7'b0, empty}, 8'h01);
        check("midreset_full", {7'b0, full}, 8'h00);
        #2 rst = 1'b1;
        cycle(1, 0, 8'h77);
        $display("post-reset write 77 -> data_out=%h empty=%b", data_out, empty);
        check("post_reset_wr_empty", {7'b0, empty}, 8'h00);
        cycle(0, 1, 8'h00);
        $display("post-reset read -> data_out=%h empty=%b", data_out, empty);
        check("post_reset_rd_data", data_out, 8'h77);
        check("post_reset_rd_empty", {7'b0, empty}, 8'h01);
        cycle(0, 1, 8'h00);
        $display("post-reset extra read -> data_out=%h empty=%b", data_out, empty);
        check("post_reset_hold_data", data_out, 8'h77);
        check("post_reset_hold_empty", {7'b0, empty}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
